riscv_uart_programmer: RTL

UART boot-loader front end that produces the `upg_*` programming interface consumed by the data-cache / IO bridge. Receives a length-prefixed byte stream on a serial line, assembles little-endian 32-bit words, and issues one write strobe per word at incrementing word addresses. Signals completion with `upg_done_o`. Sits between the board UART RX pin and the memory programming ports, in the same clock domain as the cache.

---
 rtl/riscv_uart_programmer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_uart_programmer.sv
// riscv_uart_programmer
// UART boot-loader front end. Receives a length-prefixed byte stream
// (2 length bytes, little-endian N, then N little-endian 32-bit words) and
// drives the upg_* programming interface with one write strobe per word.
//
// Optional feature macro: UPG_CHECKSUM_EN
//   When defined, one trailing byte carrying the XOR of all payload bytes
//   must follow the last word; a mismatch flags upg_err_o instead of done.
//
// Ports:
//   clk           single clock, also forwarded on upg_clk_o
//   rst_n         asynchronous active-low reset
//   rx_i          UART serial input (idle high, asynchronous)
//   prog_start_i  level; starts a session when sampled in P_IDLE / P_DONE
//   upg_rst_o     high while no session is active
//   upg_clk_o     copy of clk
//   upg_wen_o     one-cycle word write strobe
//   upg_adr_o     14-bit word address, held until the next write
//   upg_dat_o     32-bit write data, held until the next write
//   upg_done_o    session completed
//   upg_err_o     sticky length / checksum error
//   frame_err_o   sticky bad-stop-bit indication
module riscv_uart_programmer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int MAX_WORDS    = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  input  logic        prog_start_i,
  output logic        upg_rst_o,
  output logic        upg_clk_o,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o,
  output logic        frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [16:0]   MAX_N    = 17'(MAX_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE, P_LEN0, P_LEN1, P_WORD,
`ifdef UPG_CHECKSUM_EN
    P_CSUM,
`endif
    P_DONE
  } p_state_t;

  // ---------------- RX front end ----------------
  logic            rx_meta, rx_sync;
  rx_state_t       r_state;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            byte_valid;
  logic            frame_bad;

  // Both synchronizer flops reset to the idle (high) line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  // The bit counter expires when it reaches 1, so a load of K means the
  // sample is taken K cycles later: half a bit lands mid start bit, then a
  // full bit per data/stop sample keeps sampling centred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_bad  <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (!rx_sync) begin
            r_state <= R_START;
            bit_cnt <= HALF_BIT;
          end
        end
        R_START: begin
          if (bit_cnt == CW'(1)) begin
            if (rx_sync) begin
              r_state <= R_IDLE;
            end else begin
              r_state <= R_DATA;
              bit_cnt <= FULL_BIT;
              bit_idx <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        R_DATA: begin
          if (bit_cnt == CW'(1)) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_cnt  <= FULL_BIT;
            if (bit_idx == 3'd7) r_state <= R_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        R_STOP: begin
          if (bit_cnt == CW'(1)) begin
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_bad  <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- Protocol FSM ----------------
  p_state_t      p_state;
  logic [7:0]    len_lo;
  logic [15:0]   len_q;
  logic [15:0]   len_in;
  logic [14:0]   word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // rx_shift holds the last byte until the next frame's data bits arrive,
  // well after byte_valid has been consumed.
  assign len_in     = {rx_shift, len_lo};
  assign upg_rst_o  = (p_state == P_IDLE);
  assign upg_done_o = (p_state == P_DONE);
  assign upg_clk_o  = clk;

  // The end-of-payload check runs in the strobe cycle, when word_idx has
  // already advanced, which places done one cycle after the last strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= P_IDLE;
      len_lo      <= '0;
      len_q       <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      word_buf    <= '0;
      upg_wen_o   <= 1'b0;
      upg_adr_o   <= '0;
      upg_dat_o   <= '0;
      upg_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      upg_wen_o <= 1'b0;
      if (frame_bad) frame_err_o <= 1'b1;
      case (p_state)
        P_IDLE, P_DONE: begin
          // A start here overrides any byte arriving in the same cycle.
          if (prog_start_i) begin
            p_state     <= P_LEN0;
            word_idx    <= '0;
            byte_idx    <= '0;
            upg_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            csum        <= '0;
`endif
          end
        end
        P_LEN0: begin
          if (byte_valid) begin
            len_lo  <= rx_shift;
            p_state <= P_LEN1;
          end
        end
        P_LEN1: begin
          if (byte_valid) begin
            len_q <= len_in;
            if ({1'b0, len_in} > MAX_N) begin
              upg_err_o <= 1'b1;
              p_state   <= P_IDLE;
            end else if (len_in == 16'd0) begin
`ifdef UPG_CHECKSUM_EN
              p_state <= P_CSUM;
`else
              p_state <= P_DONE;
`endif
            end else begin
              p_state <= P_WORD;
            end
          end
        end
        P_WORD: begin
          if (upg_wen_o && ({1'b0, word_idx} == len_q)) begin
`ifdef UPG_CHECKSUM_EN
            p_state <= P_CSUM;
`else
            p_state <= P_DONE;
`endif
          end else if (byte_valid) begin
`ifdef UPG_CHECKSUM_EN
            csum <= csum ^ rx_shift;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              upg_wen_o <= 1'b1;
              upg_adr_o <= word_idx[13:0];
              upg_dat_o <= {rx_shift, word_buf};
              word_idx  <= word_idx + 15'd1;
            end else begin
              word_buf <= {rx_shift, word_buf[23:8]};
            end
          end
        end
`ifdef UPG_CHECKSUM_EN
        P_CSUM: begin
          if (byte_valid) begin
            if (rx_shift == csum) begin
              p_state <= P_DONE;
            end else begin
              upg_err_o <= 1'b1;
              p_state   <= P_IDLE;
            end
          end
        end
`endif
        default: p_state <= P_IDLE;
      endcase
    end
  end

endmodule
